// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - prefetching instruction fetch stage with redirect and misaligned-target fault
module instr_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {RUN, FAULT} mode_t;

    mode_t         mode;
    logic [31:0]   fetch_pc;
    logic [31:0]   fault_pc;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   fl_pc  [DEPTH];
    logic [AW-1:0] q_wr, q_rd, fl_wr, fl_rd;
    logic [CW-1:0] q_count, outstanding, discard;

    logic          req_accept, rsp_take, push, pop;
    logic [CW-1:0] outstanding_next;

    // Credit rule: queued plus in-flight words never exceed the queue size,
    // so every surviving response is guaranteed a slot.
    assign o_imem_req_valid = !i_rst && (mode == RUN) &&
                              (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_W);
    assign o_imem_req_addr  = fetch_pc;

    assign req_accept       = o_imem_req_valid && i_imem_req_ready;
    assign rsp_take         = i_imem_rsp_valid && (outstanding != '0);
    assign push             = rsp_take && (discard == '0) && !i_redirect_valid && (mode == RUN);
    assign pop              = (mode == RUN) && (q_count != '0) && i_inst_ready;
    assign outstanding_next = outstanding + CW'(req_accept) - CW'(rsp_take);

    assign o_inst_valid = (mode == FAULT) || (q_count != '0);
    assign o_inst_fault = (mode == FAULT);
    assign o_inst       = ((mode == RUN) && (q_count != '0)) ? q_inst[q_rd] : '0;
    assign o_inst_pc    = (mode == FAULT) ? fault_pc :
                          ((q_count != '0) ? q_pc[q_rd] : '0);

    always_ff @(posedge i_clk) begin
        if (req_accept) fl_pc[fl_wr] <= fetch_pc;
        if (push) begin
            q_inst[q_wr] <= i_imem_rsp_data;
            q_pc[q_wr]   <= fl_pc[fl_rd];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode        <= RUN;
            fetch_pc    <= RESET_ADDR;
            fault_pc    <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            fl_wr       <= '0;
            fl_rd       <= '0;
            q_count     <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (req_accept) fl_wr <= fl_wr + ONE_A;
            if (rsp_take)   fl_rd <= fl_rd + ONE_A;
            if (i_redirect_valid) begin
                // Everything still in flight, including a request accepted
                // this cycle, belongs to the old path and must be dropped.
                q_wr    <= '0;
                q_rd    <= '0;
                q_count <= '0;
                discard <= outstanding_next;
                if (i_redirect_pc[1:0] == 2'b00) begin
                    mode     <= RUN;
                    fetch_pc <= i_redirect_pc;
                end else begin
                    mode     <= FAULT;
                    fault_pc <= i_redirect_pc;
                end
            end else begin
                if (req_accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)       q_wr     <= q_wr + ONE_A;
                if (pop)        q_rd     <= q_rd + ONE_A;
                q_count <= q_count + CW'(push) - CW'(pop);
                if (rsp_take && (discard != '0)) discard <= discard - ONE_C;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!(i_imem_rsp_valid && (outstanding == '0)));
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a stream-level model
module tb_instr_fetch;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, imem_req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_fault     (inst_fault)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    logic [31:0] pipe_addr [$];
    int          pipe_due  [$];
    int          last_due;
    int          lat_min = 1, lat_max = 1;
    int          rdy_pct = 100, mem_rdy_pct = 100;

    logic [31:0] exp_pc, exp_req, fault_pc;
    bit          in_fault, just_redirected, throughput_chk, prev_req_stall;
    logic [31:0] prev_req_addr;
    int          delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_restart();
        pipe_addr.delete();
        pipe_due.delete();
        last_due        = cycle;
        exp_pc          = RESET_ADDR;
        exp_req         = RESET_ADDR;
        in_fault        = 1'b0;
        just_redirected = 1'b1;
        prev_req_stall  = 1'b0;
        throughput_chk  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check("rst_req_valid",  req_valid,  0);
            check("rst_inst_valid", inst_valid, 0);
            check("rst_inst_fault", inst_fault, 0);
            check("rst_inst",       inst,       0);
            check("rst_inst_pc",    inst_pc,    0);
            cycle++;
        end
        rst = 1'b0;
        model_restart();
        #1;
        check("post_rst_req_valid", req_valid,  1);
        check("post_rst_req_addr",  req_addr,   RESET_ADDR);
        check("post_rst_inst_valid", inst_valid, 0);
        check("post_rst_inst_pc",   inst_pc,    0);
        check("post_rst_inst",      inst,       0);
    endtask

    task automatic run_cycle(input bit redir, input logic [31:0] tgt);
        bit acc, cons;
        int due;
        redirect_valid = redir;
        redirect_pc    = tgt;
        inst_ready     = ($urandom_range(99) < rdy_pct);
        imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        if (pipe_due.size() != 0 && pipe_due[0] <= cycle) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pipe_addr[0]);
            void'(pipe_due.pop_front());
            void'(pipe_addr.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;
        if (in_fault) begin
            check("fault_valid", inst_valid, 1);
            check("fault_flag",  inst_fault, 1);
            check("fault_pc",    inst_pc,    fault_pc);
            check("fault_inst",  inst,       0);
            check("fault_noreq", req_valid,  0);
        end else begin
            check("head_fault", inst_fault, 0);
            if (just_redirected) check("redirect_flush", inst_valid, 0);
            if (throughput_chk)  check("throughput",     inst_valid, 1);
            if (inst_valid) begin
                check("head_pc",   inst_pc, exp_pc);
                check("head_inst", inst,    mem_word(exp_pc));
            end
            if (prev_req_stall) begin
                check("req_hold_valid", req_valid, 1);
                check("req_hold_addr",  req_addr,  prev_req_addr);
            end
        end
        acc  = req_valid && imem_req_ready;
        cons = inst_valid && inst_ready;
        if (acc) begin
            check("req_addr", req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            due = cycle + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pipe_addr.push_back(req_addr);
            pipe_due.push_back(due);
        end
        prev_req_stall = req_valid && !imem_req_ready && !redir;
        prev_req_addr  = req_addr;
        if (cons && !in_fault && !redir) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        just_redirected = 1'b0;
        if (redir) begin
            if (tgt[1:0] == 2'b00) begin
                in_fault        = 1'b0;
                exp_pc          = tgt;
                exp_req         = tgt;
                just_redirected = 1'b1;
            end else begin
                in_fault = 1'b1;
                fault_pc = tgt;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic run(input int n);
        repeat (n) run_cycle(1'b0, '0);
    endtask

    initial begin
        int d0;
        logic [31:0] tgt;
        delivered = 0;

        do_reset(3);
        run(2);
        #1;
        check("first_visible_valid", inst_valid, 1);
        check("first_visible_pc",    inst_pc,    RESET_ADDR);
        throughput_chk = 1'b1;
        run(20);
        throughput_chk = 1'b0;

        rdy_pct = 0;
        run(10);
        #1;
        check("full_no_req",   req_valid,  0);
        check("full_head_val", inst_valid, 1);
        rdy_pct = 100;
        run(10);

        lat_min = 3; lat_max = 3;
        run(8);
        d0 = delivered;
        run_cycle(1'b1, 32'h0000_0100);
        run(12);
        check("redir_progress", (delivered > d0), 1);

        run_cycle(1'b1, 32'h0000_0102);
        run(6);
        d0 = delivered;
        run_cycle(1'b1, 32'h0000_0200);
        run(12);
        check("fault_resume_progress", (delivered > d0), 1);

        lat_min = 1; lat_max = 1;
        mem_rdy_pct = 0;
        run(5);
        mem_rdy_pct = 100;
        run(10);

        d0 = delivered;
        run_cycle(1'b1, 32'hFFFF_FFF8);
        run(10);
        check("wrap_progress", (delivered > d0 + 3), 1);

        lat_min = 2; lat_max = 2;
        run_cycle(1'b1, 32'h0000_0300);
        run(10);
        throughput_chk = 1'b1;
        run(20);
        throughput_chk = 1'b0;

        lat_min = 3; lat_max = 3;
        rdy_pct = 0;
        run(5);
        do_reset(1);
        rdy_pct = 100;
        lat_min = 1; lat_max = 1;
        d0 = delivered;
        run(10);
        check("post_midrst_progress", (delivered > d0), 1);

        d0 = delivered;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) begin
                rdy_pct     = $urandom_range(100, 30);
                mem_rdy_pct = $urandom_range(100, 30);
                lat_max     = $urandom_range(5, 1);
            end
            if ($urandom_range(99) < 4) begin
                tgt = $urandom & 32'h0000_3FFC;
                if ($urandom_range(3) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
                run_cycle(1'b1, tgt);
            end else begin
                run_cycle(1'b0, '0);
            end
        end
        check("random_progress", (delivered > d0 + 200), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage placed directly upstream of the hart's decode/execute logic. Replaces the combinational imem port with a request/response memory interface of arbitrary in-order latency, prefetches sequential words into a small instruction queue, and hands instructions plus their PC to the hart over a valid/ready handshake. Handles control-flow redirects (taken branch/jump), discarding stale in-flight responses and flagging misaligned targets.

## Interface
- RESET_ADDR, 32'h00000000, first fetch PC after reset.
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, >= 2.

- i_clk  in  1  global clock.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- o_imem_req_valid  out  1  fetch request valid.
- i_imem_req_ready  in  1  memory accepts request when high with valid.
- o_imem_req_addr  out  32  word-aligned fetch address.
- i_imem_rsp_valid  in  1  response word valid; in order, earliest one cycle after acceptance.
- i_imem_rsp_data  in  32  instruction word.
- i_redirect_valid  in  1  hart requests fetch from new PC.
- i_redirect_pc  in  32  redirect target.
- o_inst_valid  out  1  queue head valid.
- i_inst_ready  in  1  hart consumes head when high with valid.
- o_inst  out  32  head instruction word (0 for fault entry).
- o_inst_pc  out  32  PC of head.
- o_inst_fault  out  1  head is a misaligned-target fault entry.

## Operation
- State: fetch_pc (32b), queue of DEPTH {inst, pc}, outstanding count, discard count, mode in {RUN, FAULT}. Counters are log2(DEPTH)+1 bits.
- Request issue: o_imem_req_valid = (mode==RUN) && (occupancy + outstanding < DEPTH); o_imem_req_addr = fetch_pc. On accept, fetch_pc += 4 (wraps 0xFFFFFFFC -> 0x00000000), outstanding++. Request address/valid held stable until accepted.
- Each issued request records its PC in a DEPTH-entry in-flight PC FIFO; response pairs with oldest entry.
- Response: outstanding--. If discard > 0: discard--, word dropped. Else word + paired PC enqueued (space guaranteed by credit rule).
- Dequeue: head popped when o_inst_valid && i_inst_ready.
- Redirect (highest priority, same cycle as any other event):
  - queue flushed; pops that cycle ignored.
  - discard := outstanding after this cycle's accept/response (request accepted in redirect cycle counts as stale).
  - target[1:0]==0: fetch_pc := target, mode RUN.
  - target[1:0]!=0: mode FAULT; no requests issued; head presents o_inst_valid=1, o_inst_fault=1, o_inst_pc=target, o_inst=0 until next redirect; popping it does not clear it.
- Response with outstanding==0 is a protocol violation: ignored, covered by assertion.
- Reset: fetch_pc=RESET_ADDR, queue empty, outstanding=0, discard=0, mode RUN. Reset mid-operation abandons in-flight requests; the memory is reset on the same i_rst.

## Timing
- Reset values (during and first cycle after reset): o_inst_valid=0, o_inst_fault=0, o_inst=0, o_inst_pc=0; o_imem_req_valid=0 during reset, 1 in first cycle after with o_imem_req_addr=RESET_ADDR.
- Queue outputs registered: response in cycle M -> o_inst_valid in M+1. No bypass.
- Minimum fetch-to-decode latency: accept N, response N+1, visible N+2.
- Sustained one instruction per cycle when memory latency < DEPTH and hart always ready.
- Redirect in cycle R: o_inst_valid=0 in R+1 (RUN), first request to target in R+1; fault entry visible in R+1 (FAULT).
- o_imem_req_valid, o_imem_req_addr depend only on registered state (no combinational path from i_redirect_valid or i_inst_ready).

## Test plan
- Reset, 1-cycle memory, hart always ready -> requests 0x0,0x4,0x8...; o_inst_pc 0x0 at cycle 2 after reset, then +4 every cycle.
- i_inst_ready low 10 cycles, DEPTH=4 -> occupancy reaches 4, o_imem_req_valid=0, no words lost; resume yields contiguous PCs.
- 3-cycle latency, redirect to 0x100 with 3 outstanding -> 3 responses dropped; next o_inst_pc=0x100, then 0x104.
- Redirect to 0x102 -> o_inst_fault=1, o_inst_pc=0x102, o_inst=0 held across pops; no requests; redirect to 0x200 resumes.
- i_imem_req_ready low 5 cycles -> address held at same value, fetch_pc unchanged; stream continues without gaps.
- i_rst asserted with 2 outstanding and 3 queued -> after reset o_inst_valid=0, first request RESET_ADDR, no stale words delivered.
